// File: rtl/sig_change_logger.sv
// Change recorder: pushes {timestamp, new value} into a first-word-fall-through FIFO whenever sig_in changes.
// Define SIG_LOGGER_WRAP_MARK_EN to add out_wrap and push a marker entry whenever the timestamp wraps.
`timescale 1ns/1ps
module sig_change_logger #(
  parameter int DATA_W = 4,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DATA_W-1:0]        sig_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [TS_W-1:0]          out_ts,
`ifdef SIG_LOGGER_WRAP_MARK_EN
  output logic                     out_wrap,
`endif
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BASELINE,
    S_RUN
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [TS_W-1:0]     r_ts;
  logic [DATA_W-1:0]   r_last;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  logic                r_overflow;

  logic [DATA_W-1:0]   r_mem_data [DEPTH];
  logic [TS_W-1:0]     r_mem_ts   [DEPTH];

  logic                w_change;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_push_ok;
  logic                w_drop;
  logic [DATA_W-1:0]   w_push_data;
  logic [TS_W-1:0]     w_push_ts;

`ifdef SIG_LOGGER_WRAP_MARK_EN
  logic                r_mem_wrap [DEPTH];
  logic                r_pend_vld;
  logic [DATA_W-1:0]   r_pend_data;
  logic [TS_W-1:0]     r_pend_ts;
  logic                w_wrap_evt;
  logic                w_push_wrap;
  logic                w_pend_load;
  logic                w_pend_vld_nxt;
  logic                w_lost;
`endif

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (en) w_next_state = S_BASELINE;
      S_BASELINE: w_next_state = en ? S_RUN : S_IDLE;
      S_RUN:      if (!en) w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  assign w_change = (r_state == S_RUN) && (sig_in != r_last);
  assign w_full   = (r_level == LVL_W'(DEPTH));
  assign w_pop    = out_valid && out_ready;

`ifdef SIG_LOGGER_WRAP_MARK_EN
  assign w_wrap_evt = (r_state == S_RUN) && (r_ts == '0);

  // A wrap marker takes the slot; a same-cycle change waits one cycle in the pending register.
  always_comb begin
    w_push         = 1'b0;
    w_push_data    = sig_in;
    w_push_ts      = r_ts;
    w_push_wrap    = 1'b0;
    w_pend_load    = 1'b0;
    w_pend_vld_nxt = r_pend_vld;
    w_lost         = 1'b0;
    if (w_wrap_evt) begin
      w_push         = 1'b1;
      w_push_data    = r_last;
      w_push_ts      = '0;
      w_push_wrap    = 1'b1;
      w_lost         = r_pend_vld;
      w_pend_load    = w_change;
      w_pend_vld_nxt = w_change;
    end else if (r_pend_vld) begin
      w_push         = 1'b1;
      w_push_data    = r_pend_data;
      w_push_ts      = r_pend_ts;
      w_pend_load    = w_change;
      w_pend_vld_nxt = w_change;
    end else begin
      w_push         = w_change;
    end
  end

  assign w_drop = (w_push && w_full && !w_pop) || w_lost;
`else
  assign w_push      = w_change;
  assign w_push_data = sig_in;
  assign w_push_ts   = r_ts;
  assign w_drop      = w_push && w_full && !w_pop;
`endif

  assign w_push_ok = w_push && (!w_full || w_pop);

  // ---------------------------------------------------------------------------
  // State, timestamp and FIFO control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state     <= S_IDLE;
      r_ts        <= '0;
      r_last      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
`ifdef SIG_LOGGER_WRAP_MARK_EN
      r_pend_vld  <= 1'b0;
      r_pend_data <= '0;
      r_pend_ts   <= '0;
`endif
    end else begin
      r_state <= w_next_state;
      r_ts    <= r_ts + 1'b1;
      // Last value tracks sig_in even when the event itself is dropped on a full FIFO.
      if (r_state == S_BASELINE || w_change) r_last <= sig_in;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + LVL_W'(w_push_ok) - LVL_W'(w_pop);
      if (w_drop) r_overflow <= 1'b1;
`ifdef SIG_LOGGER_WRAP_MARK_EN
      r_pend_vld <= w_pend_vld_nxt;
      if (w_pend_load) begin
        r_pend_data <= sig_in;
        r_pend_ts   <= r_ts;
      end
`endif
    end
  end

  // NOTE: storage is not reset; the pointers and level define validity and outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem_data[r_wr_ptr] <= w_push_data;
      r_mem_ts[r_wr_ptr]   <= w_push_ts;
`ifdef SIG_LOGGER_WRAP_MARK_EN
      r_mem_wrap[r_wr_ptr] <= w_push_wrap;
`endif
    end
  end

  assign out_valid = (r_level != '0);
  assign out_data  = out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign out_ts    = out_valid ? r_mem_ts[r_rd_ptr]   : '0;
`ifdef SIG_LOGGER_WRAP_MARK_EN
  assign out_wrap  = out_valid ? r_mem_wrap[r_rd_ptr] : 1'b0;
`endif
  assign level     = r_level;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_sig_change_logger.sv
// Directed self-checking bench for sig_change_logger; the wrap-marker scenario runs on a TS_W=4 instance
// only when SIG_LOGGER_WRAP_MARK_EN is defined.
`timescale 1ns/1ps
module tb_sig_change_logger;

  localparam int DATA_W = 4;
  localparam int TS_W   = 16;
  localparam int DEPTH  = 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst, en, out_ready;
  logic [DATA_W-1:0] sig_in;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [TS_W-1:0]   out_ts;
  logic [LVL_W-1:0]  level;
  logic              overflow;
`ifdef SIG_LOGGER_WRAP_MARK_EN
  logic              out_wrap;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Reference timestamp: the value the DUT stamps on the next edge.
  logic [TS_W-1:0] m_ts;
  always @(posedge clk) if (rst) m_ts <= '0; else m_ts <= m_ts + 1'b1;

  sig_change_logger #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ts(out_ts),
`ifdef SIG_LOGGER_WRAP_MARK_EN
    .out_wrap(out_wrap),
`endif
    .level(level), .overflow(overflow)
  );

`ifdef SIG_LOGGER_WRAP_MARK_EN
  logic        wr_rst, wr_en, wr_ready, wr_valid, wr_wrap, wr_ovf;
  logic [3:0]  wr_sig, wr_data, wr_ts, m_wts;
  logic [LVL_W-1:0] wr_level;

  always @(posedge clk) if (wr_rst) m_wts <= '0; else m_wts <= m_wts + 1'b1;

  sig_change_logger #(.DATA_W(4), .TS_W(4), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst(wr_rst), .en(wr_en), .sig_in(wr_sig),
    .out_valid(wr_valid), .out_ready(wr_ready), .out_data(wr_data), .out_ts(wr_ts),
    .out_wrap(wr_wrap), .level(wr_level), .overflow(wr_ovf)
  );
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ts(input logic [TS_W-1:0] target);
    for (int k = 0; k < 200 && m_ts != target; k++) step();
    n_tests++;
    if (m_ts !== target) begin n_fail++; $display("FAIL wait_ts: reached %0d, wanted %0d", m_ts, target); end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; sig_in = 4'h3; out_ready = 1'b0;
    step(); step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_tests++; if (level !== '0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", level); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    n_tests++; if (out_data !== '0 || out_ts !== '0) begin n_fail++; $display("FAIL rst_head: got %h/%0d want 0/0", out_data, out_ts); end
    rst = 1'b0;
    repeat (4) step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL baseline_valid: got %b want 0", out_valid); end
    n_tests++; if (level !== '0) begin n_fail++; $display("FAIL baseline_level: got %0d want 0", level); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL baseline_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_single_change();
    out_ready = 1'b1;
    wait_ts(16'd10);
    sig_in = 4'h5;
    step();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_tests++; if (out_data !== 4'h5) begin n_fail++; $display("FAIL single_data: got %h want 5", out_data); end
    n_tests++; if (out_ts !== 16'd10) begin n_fail++; $display("FAIL single_ts: got %0d want 10", out_ts); end
    n_tests++; if (level !== 4'd1) begin n_fail++; $display("FAIL single_level: got %0d want 1", level); end
    step();
    n_tests++; if (out_valid !== 1'b0 || level !== '0) begin n_fail++; $display("FAIL single_drain: got valid %b level %0d want 0/0", out_valid, level); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] exp_d [3];
    logic [TS_W-1:0]   exp_t [3];
    exp_d = '{4'h2, 4'h4, 4'h8};
    exp_t = '{16'd20, 16'd21, 16'd22};
    wait_ts(16'd15);
    sig_in = 4'h1;
    step(); step();
    wait_ts(16'd20);
    out_ready = 1'b0;
    sig_in = 4'h2; step();
    sig_in = 4'h4; step();
    sig_in = 4'h8; step();
    n_tests++; if (level !== 4'd3) begin n_fail++; $display("FAIL bp_level: got %0d want 3", level); end
    n_tests++; if (out_data !== 4'h2 || out_ts !== 16'd20) begin n_fail++; $display("FAIL bp_head: got %h/%0d want 2/20", out_data, out_ts); end
    repeat (3) step();
    n_tests++; if (out_valid !== 1'b1 || out_data !== 4'h2 || out_ts !== 16'd20 || level !== 4'd3)
      begin n_fail++; $display("FAIL bp_hold: got v%b %h/%0d lvl %0d want v1 2/20 lvl 3", out_valid, out_data, out_ts, level); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (out_data !== exp_d[i] || out_ts !== exp_t[i])
        begin n_fail++; $display("FAIL bp_drain%0d: got %h/%0d want %h/%0d", i, out_data, out_ts, exp_d[i], exp_t[i]); end
      step();
    end
    n_tests++; if (out_valid !== 1'b0 || level !== '0) begin n_fail++; $display("FAIL bp_empty: got valid %b level %0d want 0/0", out_valid, level); end
  endtask

  task automatic test_overflow();
    logic [TS_W-1:0] t0;
    out_ready = 1'b0;
    t0 = m_ts;
    for (int i = 0; i < 9; i++) begin
      sig_in = DATA_W'(i);
      step();
    end
    n_tests++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d want 8", level); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_tests++; if (out_data !== 4'h0 || out_ts !== t0) begin n_fail++; $display("FAIL ovf_head: got %h/%0d want 0/%0d", out_data, out_ts, t0); end
    out_ready = 1'b1;
    sig_in = 4'h9;
    step();
    n_tests++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_pushpop_level: got %0d want 8", level); end
    for (int i = 1; i < 8; i++) begin
      n_tests++; if (out_data !== DATA_W'(i) || out_ts !== t0 + TS_W'(i))
        begin n_fail++; $display("FAIL ovf_entry%0d: got %h/%0d want %h/%0d", i, out_data, out_ts, i, t0 + TS_W'(i)); end
      step();
    end
    n_tests++; if (out_data !== 4'h9 || out_ts !== t0 + 16'd9) begin n_fail++; $display("FAIL ovf_last: got %h/%0d want 9/%0d", out_data, out_ts, t0 + 16'd9); end
    step();
    n_tests++; if (out_valid !== 1'b0 || level !== '0) begin n_fail++; $display("FAIL ovf_empty: got valid %b level %0d want 0/0", out_valid, level); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_en_gating_reset();
    en = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      sig_in = ~sig_in;
      step();
    end
    n_tests++; if (level !== '0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL gate_idle: got level %0d valid %b want 0/0", level, out_valid); end
    en = 1'b1;
    repeat (4) step();
    n_tests++; if (level !== '0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL gate_rebaseline: got level %0d valid %b want 0/0", level, out_valid); end
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sig_in = DATA_W'(i);
      step();
    end
    n_tests++; if (level !== 4'd4) begin n_fail++; $display("FAIL midrst_pre_level: got %0d want 4", level); end
    rst = 1'b1;
    sig_in = 4'h7;
    step();
    n_tests++; if (level !== '0) begin n_fail++; $display("FAIL midrst_level: got %0d want 0", level); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow: got %b want 0", overflow); end
    rst = 1'b0;
    repeat (4) step();
    n_tests++; if (level !== '0) begin n_fail++; $display("FAIL postrst_level: got %0d want 0", level); end
  endtask

`ifdef SIG_LOGGER_WRAP_MARK_EN
  task automatic test_wrap();
    wr_rst = 1'b1; wr_en = 1'b1; wr_sig = 4'h3; wr_ready = 1'b0;
    step(); step();
    wr_rst = 1'b0;
    for (int k = 0; k < 40 && m_wts != 4'd15; k++) step();
    step();
    n_tests++; if (m_wts !== 4'd0 || wr_level !== '0) begin n_fail++; $display("FAIL wrap_pre: got ts %0d level %0d want 0/0", m_wts, wr_level); end
    wr_sig = 4'h6;
    step();
    n_tests++; if (wr_valid !== 1'b1 || wr_wrap !== 1'b1 || wr_ts !== 4'd0 || wr_data !== 4'h3)
      begin n_fail++; $display("FAIL wrap_marker: got v%b w%b ts %0d d %h want v1 w1 ts 0 d 3", wr_valid, wr_wrap, wr_ts, wr_data); end
    step();
    n_tests++; if (wr_level !== 4'd2) begin n_fail++; $display("FAIL wrap_level: got %0d want 2", wr_level); end
    wr_ready = 1'b1;
    step();
    n_tests++; if (wr_valid !== 1'b1 || wr_wrap !== 1'b0 || wr_ts !== 4'd0 || wr_data !== 4'h6)
      begin n_fail++; $display("FAIL wrap_change: got v%b w%b ts %0d d %h want v1 w0 ts 0 d 6", wr_valid, wr_wrap, wr_ts, wr_data); end
    step();
    n_tests++; if (wr_valid !== 1'b0 || wr_ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got valid %b ovf %b want 0/0", wr_valid, wr_ovf); end
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; sig_in = '0; out_ready = 1'b0;
`ifdef SIG_LOGGER_WRAP_MARK_EN
    wr_rst = 1'b1; wr_en = 1'b0; wr_sig = '0; wr_ready = 1'b0;
`endif
    test_reset();
    test_single_change();
    test_backpressure();
    test_overflow();
    test_en_gating_reset();
`ifdef SIG_LOGGER_WRAP_MARK_EN
    test_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
